parallel_to_serial_tx: RTL and testbench

PARALLEL_TO_SERIAL_TX -- requirements
Module: parallel_to_serial_tx

---
 rtl/parallel_to_serial_tx_pkg.sv | 11 +
 rtl/parallel_to_serial_tx_frame_bit_counter.sv | 23 ++
 rtl/parallel_to_serial_tx.sv | 69 ++++++
 tb/tb_parallel_to_serial_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/parallel_to_serial_tx_pkg.sv
// rtl/parallel_to_serial_tx_pkg.sv - shared types and constants for the parallel-to-serial transmitter
package parallel_to_serial_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/parallel_to_serial_tx_frame_bit_counter.sv
// rtl/parallel_to_serial_tx_frame_bit_counter.sv - bit position counter within a frame
module frame_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          enable,
  output logic [CW-1:0] count
);

  // load wins over enable so a back-to-back accept restarts at bit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parallel_to_serial_tx.sv
// rtl/parallel_to_serial_tx.sv - serializes WIDTH-bit words onto sout with valid/last framing
module parallel_to_serial_tx
  import parallel_to_serial_tx_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    count;
  logic             in_shift;
  logic             at_last;
  logic             accept;

  assign in_shift = (state == SHIFT);
  assign at_last  = in_shift && (count == LAST);
  assign accept   = din_valid && din_ready;

  assign shreg_next = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                       : {1'b0, shreg[WIDTH-1:1]};

  frame_bit_counter #(
    .CW(CW)
  ) u_frame_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .enable (in_shift && !at_last),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= din;
    end else if (in_shift) begin
      shreg <= shreg_next;
      if (at_last) begin
        state <= IDLE;
      end
    end
  end

  // All outputs decode directly from registered state, so they never follow din_valid
  assign din_ready  = !in_shift || at_last;
  assign busy       = in_shift;
  assign sout_valid = in_shift;
  assign sout_last  = at_last;
  assign sout       = in_shift && ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// tb/tb_parallel_to_serial_tx.sv - directed self-checking bench for parallel_to_serial_tx
module tb_parallel_to_serial_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] din_m = 8'h00;
  logic       dv_m = 1'b0;
  logic       ready_m, sout_m, valid_m, last_m, busy_m;

  logic [7:0] din_l = 8'h00;
  logic       dv_l = 1'b0;
  logic       ready_l, sout_l, valid_l, last_l, busy_l;

  logic [7:0] rx_q = 8'h00;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  parallel_to_serial_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .din        (din_m),
    .din_valid  (dv_m),
    .din_ready  (ready_m),
    .sout       (sout_m),
    .sout_valid (valid_m),
    .sout_last  (last_m),
    .busy       (busy_m)
  );

  parallel_to_serial_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .din        (din_l),
    .din_valid  (dv_l),
    .din_ready  (ready_l),
    .sout       (sout_l),
    .sout_valid (valid_l),
    .sout_last  (last_l),
    .busy       (busy_l)
  );

  // Receiver model: D shifts into Q0 toward Q7 on each frame bit
  always @(posedge clk) begin
    if (valid_m) rx_q <= {rx_q[6:0], sout_m};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_m(input string tag);
    check({tag, " valid"}, valid_m, 1'b0);
    check({tag, " busy"},  busy_m,  1'b0);
    check({tag, " last"},  last_m,  1'b0);
    check({tag, " sout"},  sout_m,  1'b0);
    check({tag, " ready"}, ready_m, 1'b1);
  endtask

  task automatic check_bit_m(input string tag, input int i, input logic exp_bit, input logic exp_last);
    check($sformatf("%s sout c%0d", tag, i + 1), sout_m, exp_bit);
    check($sformatf("%s valid c%0d", tag, i + 1), valid_m, 1'b1);
    check($sformatf("%s busy c%0d", tag, i + 1), busy_m, 1'b1);
    check($sformatf("%s last c%0d", tag, i + 1), last_m, exp_last);
    check($sformatf("%s ready c%0d", tag, i + 1), ready_m, exp_last);
  endtask

  initial begin
    logic [7:0] v;
    logic [15:0] pair;

    tick();
    tick();
    check_idle_m("rst");
    check("rst lsb valid", valid_l, 1'b0);
    check("rst lsb ready", ready_l, 1'b1);
    reset = 1'b0;
    tick();
    check_idle_m("post_rst");

    // single MSB-first frame of A5
    v = 8'hA5;
    din_m = v; dv_m = 1'b1;
    tick();
    dv_m = 1'b0; din_m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check_bit_m("a5", i, v[7-i], i == 7);
      tick();
    end
    check_idle_m("a5 end");
    check("a5 loopback", rx_q, 8'hA5);

    // LSB-first frame of 01
    v = 8'h01;
    din_l = v; dv_l = 1'b1;
    tick();
    dv_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb sout c%0d", i + 1), sout_l, v[i]);
      check($sformatf("lsb valid c%0d", i + 1), valid_l, 1'b1);
      check($sformatf("lsb last c%0d", i + 1), last_l, i == 7);
      tick();
    end
    check("lsb end valid", valid_l, 1'b0);
    check("lsb end busy", busy_l, 1'b0);

    // back-to-back FF then 00 with din_valid held
    pair = 16'hFF00;
    din_m = 8'hFF; dv_m = 1'b1;
    tick();
    din_m = 8'h00;
    for (int i = 0; i < 16; i++) begin
      check_bit_m("b2b", i, pair[15-i], (i == 7) || (i == 15));
      tick();
      if (i == 7) dv_m = 1'b0;
    end
    check_idle_m("b2b end");

    // din_valid during busy cycles 2..6 must be ignored
    v = 8'hF0;
    din_m = v; dv_m = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      dv_m  = (i >= 1) && (i <= 5);
      din_m = 8'h00;
      check_bit_m("ign", i, v[7-i], i == 7);
      tick();
    end
    dv_m = 1'b0;
    check_idle_m("ign end");
    tick();
    check("ign no extra frame", valid_m, 1'b0);
    check("ign loopback", rx_q, 8'hF0);

    // reset in cycle 4 of an AA frame, then a clean 3C frame
    v = 8'hAA;
    din_m = v; dv_m = 1'b1;
    tick();
    dv_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_bit_m("aa", i, v[7-i], 1'b0);
      if (i == 3) reset = 1'b1;
      else tick();
    end
    tick();
    check_idle_m("mid_rst");
    reset = 1'b0;
    v = 8'h3C;
    din_m = v; dv_m = 1'b1;
    tick();
    dv_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_bit_m("3c", i, v[7-i], i == 7);
      tick();
    end
    check_idle_m("3c end");
    check("3c loopback", rx_q, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
